// File: rtl/asl_pkg.sv
// asl_pkg: shared constants and types for the ASL result writer.
//   - AHB-Lite transfer encodings and the fixed attribute values driven by
//     the writer (single-beat word writes, non-cacheable privileged data).
//   - wr_state_t: states of the AHB write sequencer.
//   - NO_CONF_CODE: code published when the best score misses the floor.
package asl_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NSEQ   = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [3:0]  HPROT_DATA    = 4'b0011;

    // Offset of the display slave's "done" register from its base.
    localparam logic [31:0] DONE_OFFSET   = 32'h0000_0004;

    // Shown by the display as 99: no class was confident enough.
    localparam logic [4:0]  NO_CONF_CODE  = 5'd24;

    typedef enum logic [2:0] {
        WR_ACCUM,
        WR_ADDR0,
        WR_DATA0,
        WR_ADDR1,
        WR_DATA1
    } wr_state_t;

endpackage

// File: rtl/asl_result_writer_score_argmax.sv
// score_argmax: running argmax over one frame of class scores.
//   clk, resetn     clock, asynchronous active-low reset
//   beat_i          a score beat is accepted this cycle
//   data_i          signed score of the accepted beat (beat k is class k)
//   last_i          accepted beat closes the frame
//   code_o          frame result including the current beat: winning class
//                   index, or NO_CONF_CODE when the best score is below
//                   CONF_THRESH; meaningful when frame_done_o is high
//   len_err_o       frame so far (including this beat) exceeded N_CLASSES
//   frame_done_o    last beat accepted; internal state clears at this edge
module score_argmax
    import asl_pkg::*;
#(
    parameter int                          N_CLASSES   = 24,
    parameter int                          SCORE_W     = 16,
    parameter logic signed [SCORE_W-1:0]   CONF_THRESH = '0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      beat_i,
    input  logic signed [SCORE_W-1:0] data_i,
    input  logic                      last_i,
    output logic [4:0]                code_o,
    output logic                      len_err_o,
    output logic                      frame_done_o
);

    localparam logic [4:0] N_CLS = 5'(N_CLASSES);

    logic [4:0]                idx_q, idx_d;
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic [4:0]                best_idx_q, best_idx_d;
    logic                      len_err_q, len_err_d;
    logic                      in_range;
    logic                      take;

    always_comb begin
        in_range     = idx_q < N_CLS;
        // Strict compare keeps the lower index on ties; idx 0 seeds the frame.
        take         = beat_i && in_range && ((idx_q == 5'd0) || (data_i > best_q));
        best_d       = take ? data_i : best_q;
        best_idx_d   = take ? idx_q : best_idx_q;
        // Counter saturates at N_CLASSES so overlength beats never wrap.
        idx_d        = (beat_i && in_range) ? idx_q + 5'd1 : idx_q;
        len_err_d    = len_err_q | (beat_i & ~in_range);
        frame_done_o = beat_i & last_i;
        code_o       = (best_d < CONF_THRESH) ? NO_CONF_CODE : best_idx_d;
        len_err_o    = len_err_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            len_err_q  <= 1'b0;
        end else if (frame_done_o) begin
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            len_err_q  <= len_err_d;
        end
    end

endmodule

// File: rtl/asl_result_writer.sv
// asl_result_writer: argmax of a per-class score stream, published to the
// seven-segment display slave as two AHB-Lite single writes
// (code to SSD_BASE+0x0, then 1 to SSD_BASE+0x4).
//   clk, resetn                 clock, asynchronous active-low reset
//   s_valid_i/s_ready_o         score stream handshake
//   s_data_i, s_last_i          signed score (beat k = class k), frame end
//   m_h*_o, m_hready_i          AHB-Lite master port (m_hresp_i unused: the
//                               display slave always answers OKAY)
//   result_o                    last published code (0-23, or 24)
//   result_valid_o              one-cycle pulse when the done write completes
//   busy_o                      writer is not accepting scores
//   len_err_o                   published frame had more than N_CLASSES beats
module asl_result_writer
    import asl_pkg::*;
#(
    parameter int                          N_CLASSES   = 24,
    parameter int                          SCORE_W     = 16,
    parameter logic signed [SCORE_W-1:0]   CONF_THRESH = '0,
    parameter logic [31:0]                 SSD_BASE    = 32'hD000_0000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic signed [SCORE_W-1:0] s_data_i,
    input  logic                      s_last_i,
    output logic [31:0]               m_haddr_o,
    output logic [1:0]                m_htrans_o,
    output logic                      m_hwrite_o,
    output logic [2:0]                m_hsize_o,
    output logic [2:0]                m_hburst_o,
    output logic [3:0]                m_hprot_o,
    output logic                      m_hmastlock_o,
    output logic [31:0]               m_hwdata_o,
    input  logic                      m_hready_i,
    input  logic                      m_hresp_i,
    output logic [4:0]                result_o,
    output logic                      result_valid_o,
    output logic                      busy_o,
    output logic                      len_err_o
);

    wr_state_t   state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [4:0]  code_q, code_d;
    logic        frame_err_q, frame_err_d;
    logic [4:0]  result_q, result_d;
    logic        len_err_out_q, len_err_out_d;
    logic        result_valid_q, result_valid_d;

    logic        beat;
    logic [4:0]  am_code;
    logic        am_len_err;
    logic        am_frame_done;
    logic        unused_hresp;

    assign unused_hresp = m_hresp_i;

    assign s_ready_o = (state_q == WR_ACCUM);
    assign busy_o    = ~s_ready_o;
    assign beat      = s_valid_i & s_ready_o;

    score_argmax #(
        .N_CLASSES   (N_CLASSES),
        .SCORE_W     (SCORE_W),
        .CONF_THRESH (CONF_THRESH)
    ) u_argmax (
        .clk          (clk),
        .resetn       (resetn),
        .beat_i       (beat),
        .data_i       (s_data_i),
        .last_i       (s_last_i),
        .code_o       (am_code),
        .len_err_o    (am_len_err),
        .frame_done_o (am_frame_done)
    );

    // AHB outputs are registered: each transition loads the values of the
    // state being entered, so the bus shows them in the very next cycle.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d        = state_q;
        haddr_d        = haddr_q;
        htrans_d       = htrans_q;
        hwrite_d       = hwrite_q;
        hwdata_d       = hwdata_q;
        code_d         = code_q;
        frame_err_d    = frame_err_q;
        result_d       = result_q;
        len_err_out_d  = len_err_out_q;
        result_valid_d = 1'b0;

        case (state_q)
            WR_ACCUM: begin
                if (am_frame_done) begin
                    state_d     = WR_ADDR0;
                    code_d      = am_code;
                    frame_err_d = am_len_err;
                    haddr_d     = SSD_BASE;
                    htrans_d    = HTRANS_NSEQ;
                    hwrite_d    = 1'b1;
                    hwdata_d    = {27'b0, am_code};
                end
            end
            WR_ADDR0: begin
                if (m_hready_i) begin
                    state_d  = WR_DATA0;
                    htrans_d = HTRANS_IDLE;
                end
            end
            WR_DATA0: begin
                if (m_hready_i) begin
                    state_d  = WR_ADDR1;
                    haddr_d  = SSD_BASE + DONE_OFFSET;
                    htrans_d = HTRANS_NSEQ;
                    hwrite_d = 1'b1;
                    hwdata_d = 32'h1;
                end
            end
            WR_ADDR1: begin
                if (m_hready_i) begin
                    state_d  = WR_DATA1;
                    htrans_d = HTRANS_IDLE;
                end
            end
            WR_DATA1: begin
                if (m_hready_i) begin
                    state_d        = WR_ACCUM;
                    haddr_d        = '0;
                    htrans_d       = HTRANS_IDLE;
                    hwrite_d       = 1'b0;
                    hwdata_d       = '0;
                    result_d       = code_q;
                    len_err_out_d  = frame_err_q;
                    result_valid_d = 1'b1;
                end
            end
            default: begin
                state_d  = WR_ACCUM;
                haddr_d  = '0;
                htrans_d = HTRANS_IDLE;
                hwrite_d = 1'b0;
                hwdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= WR_ACCUM;
            haddr_q        <= '0;
            htrans_q       <= HTRANS_IDLE;
            hwrite_q       <= 1'b0;
            hwdata_q       <= '0;
            code_q         <= '0;
            frame_err_q    <= 1'b0;
            result_q       <= '0;
            len_err_out_q  <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            haddr_q        <= haddr_d;
            htrans_q       <= htrans_d;
            hwrite_q       <= hwrite_d;
            hwdata_q       <= hwdata_d;
            code_q         <= code_d;
            frame_err_q    <= frame_err_d;
            result_q       <= result_d;
            len_err_out_q  <= len_err_out_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign m_haddr_o      = haddr_q;
    assign m_htrans_o     = htrans_q;
    assign m_hwrite_o     = hwrite_q;
    assign m_hwdata_o     = hwdata_q;
    assign m_hsize_o      = HSIZE_WORD;
    assign m_hburst_o     = HBURST_SINGLE;
    assign m_hprot_o      = HPROT_DATA;
    assign m_hmastlock_o  = 1'b0;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign len_err_o      = len_err_out_q;

endmodule

// File: tb/tb_asl_result_writer.sv
// Self-checking bench for asl_result_writer: directed vector table, a few
// hand-written multi-cycle sequences, and randomized frames checked against
// a max-then-first-index reference model. A small AHB slave model inserts
// configurable address/data-phase wait states and logs completed writes.
module tb_asl_result_writer;

    localparam logic [31:0] BASE = 32'hD000_0000;
    localparam logic [31:0] DONE = 32'hD000_0004;

    logic               clk = 1'b0;
    logic               resetn;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic               s_last;
    logic [31:0]        haddr;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [2:0]         hsize;
    logic [2:0]         hburst;
    logic [3:0]         hprot;
    logic               hmastlock;
    logic [31:0]        hwdata;
    logic               hready;
    logic               hresp = 1'b0;
    logic [4:0]         result;
    logic               result_valid;
    logic               busy;
    logic               len_err;

    asl_result_writer dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_valid_i      (s_valid),
        .s_ready_o      (s_ready),
        .s_data_i       (s_data),
        .s_last_i       (s_last),
        .m_haddr_o      (haddr),
        .m_htrans_o     (htrans),
        .m_hwrite_o     (hwrite),
        .m_hsize_o      (hsize),
        .m_hburst_o     (hburst),
        .m_hprot_o      (hprot),
        .m_hmastlock_o  (hmastlock),
        .m_hwdata_o     (hwdata),
        .m_hready_i     (hready),
        .m_hresp_i      (hresp),
        .result_o       (result),
        .result_valid_o (result_valid),
        .busy_o         (busy),
        .len_err_o      (len_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- AHB slave model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_log[$];
    int          aw[2];      // address-phase wait cycles, per register
    int          dw[2];      // data-phase wait cycles, per register
    bit          in_data = 1'b0;
    int          wcnt    = 0;
    logic [31:0] addr_l, data_l;

    always @(negedge clk) begin
        int sel;
        if (!resetn) begin
            hready  = 1'b1;
            in_data = 1'b0;
            wcnt    = 0;
        end else if (in_data) begin
            sel = int'(addr_l[2]);
            check("hwdata held in data phase", hwdata, data_l);
            if (wcnt < dw[sel]) begin
                hready = 1'b0;
                wcnt++;
            end else begin
                hready  = 1'b1;
                wcnt    = 0;
                in_data = 1'b0;
                wr_log.push_back('{addr: addr_l, data: hwdata});
            end
        end else if (htrans == 2'b10) begin
            sel = int'(haddr[2]);
            if (wcnt == 0) begin
                addr_l = haddr;
                data_l = hwdata;
                check("hwrite in address phase", {31'b0, hwrite}, 32'd1);
            end else begin
                check("haddr stable in wait", haddr, addr_l);
                check("hwdata stable in wait", hwdata, data_l);
            end
            if (wcnt < aw[sel]) begin
                hready = 1'b0;
                wcnt++;
            end else begin
                hready  = 1'b1;
                wcnt    = 0;
                in_data = 1'b1;
            end
        end else begin
            hready = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic signed [15:0] frame[0:31];

    task automatic drive_beats(input int first, input int n, input bit gaps);
        for (int i = first; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = frame[i];
            s_last  = (i == n - 1);
        end
    endtask

    // Waits for the publish sequence of the frame whose last beat is being
    // presented now; k counts cycles after the acceptance edge.
    task automatic expect_result(input string tag, input int exp_lat, input logic [4:0] exp_code,
                                 input bit exp_len, input bit hold, input logic signed [15:0] hold_data);
        int k    = 0;
        bit seen = 1'b0;
        wr_log.delete();
        while (k < 300 && !seen) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({tag, " busy in ADDR0"}, {31'b0, busy}, 32'd1);
                check({tag, " s_ready in ADDR0"}, {31'b0, s_ready}, 32'd0);
                check({tag, " htrans ADDR0"}, {30'b0, htrans}, 32'h2);
                check({tag, " haddr ADDR0"}, haddr, BASE);
                check({tag, " hwdata ADDR0"}, hwdata, {27'b0, exp_code});
                s_valid = hold;
                s_data  = hold_data;
                s_last  = 1'b0;
            end else if (hold && busy) begin
                check({tag, " s_ready low while busy"}, {31'b0, s_ready}, 32'd0);
            end
            if (result_valid) seen = 1'b1;
        end
        check({tag, " result_valid latency"}, k, exp_lat);
        check({tag, " result_o"}, {27'b0, result}, {27'b0, exp_code});
        check({tag, " len_err_o"}, {31'b0, len_err}, {31'b0, exp_len});
        check({tag, " write count"}, wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            check({tag, " write0 addr"}, wr_log[0].addr, BASE);
            check({tag, " write0 data"}, wr_log[0].data, {27'b0, exp_code});
            check({tag, " write1 addr"}, wr_log[1].addr, DONE);
            check({tag, " write1 data"}, wr_log[1].data, 32'h1);
        end
        @(negedge clk);
        s_valid = 1'b0;
        check({tag, " result_valid single pulse"}, {31'b0, result_valid}, 32'd0);
        check({tag, " back to idle"}, {31'b0, busy}, 32'd0);
    endtask

    // Reference: maximum over the first N_CLASSES beats, then the first
    // class holding it; below-floor maxima report 24.
    task automatic model(input int n, output logic [4:0] code, output bit lerr);
        int m  = (n < 24) ? n : 24;
        int mx = int'(frame[0]);
        for (int j = 1; j < m; j++) if (int'(frame[j]) > mx) mx = int'(frame[j]);
        code = 5'd0;
        for (int j = m - 1; j >= 0; j--) if (int'(frame[j]) == mx) code = 5'(j);
        if (mx < 0) code = 5'd24;
        lerr = (n > 24);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " htrans"}, {30'b0, htrans}, 32'd0);
        check({tag, " hwrite"}, {31'b0, hwrite}, 32'd0);
        check({tag, " haddr"}, haddr, 32'd0);
        check({tag, " hwdata"}, hwdata, 32'd0);
        check({tag, " result_o"}, {27'b0, result}, 32'd0);
        check({tag, " result_valid"}, {31'b0, result_valid}, 32'd0);
        check({tag, " busy"}, {31'b0, busy}, 32'd0);
        check({tag, " len_err"}, {31'b0, len_err}, 32'd0);
        check({tag, " s_ready"}, {31'b0, s_ready}, 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string      name;
        int         n;
        int         pk_cls;
        int         pk_val;
        int         sc_cls;
        int         sc_val;
        int         base;
        int         aw0, dw0, aw1, dw1;
        logic [4:0] exp_code;
        bit         exp_len;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        logic [4:0] mcode;
        bit         mlen;
        int         tmp;
        int         dones;
        int         pulses;

        vecs[0]  = '{"basic",         24,  7,  100, -1,   0, -50, 0, 1, 0, 1, 5'd7,  1'b0};
        vecs[1]  = '{"tie",           24,  3,  500, 12, 500,   0, 0, 1, 0, 1, 5'd3,  1'b0};
        vecs[2]  = '{"all negative",  24, -1,    0, -1,   0, -10, 0, 1, 0, 1, 5'd24, 1'b0};
        vecs[3]  = '{"overlength",    30, 26, 1000,  5, 200, -50, 0, 1, 0, 1, 5'd5,  1'b1};
        vecs[4]  = '{"recover",       24,  7,  100, -1,   0, -50, 0, 1, 0, 1, 5'd7,  1'b0};
        vecs[5]  = '{"wait states",   24, 20,    9, -1,   0,  -1, 3, 1, 0, 4, 5'd20, 1'b0};
        vecs[6]  = '{"single pos",     1,  0,   42, -1,   0,   0, 0, 1, 0, 1, 5'd0,  1'b0};
        vecs[7]  = '{"single neg",     1, -1,    0, -1,   0,  -1, 0, 1, 0, 1, 5'd24, 1'b0};
        vecs[8]  = '{"all zero",      24, -1,    0, -1,   0,   0, 0, 1, 0, 1, 5'd0,  1'b0};
        vecs[9]  = '{"last class",    24, 23,    5, -1,   0,  -5, 0, 1, 0, 1, 5'd23, 1'b0};
        vecs[10] = '{"class 24 beat", 25, 24,   99, 23,   5,  -5, 0, 1, 0, 1, 5'd23, 1'b1};

        resetn  = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        hready  = 1'b1;
        aw[0] = 0; dw[0] = 1; aw[1] = 0; dw[1] = 1;
        repeat (3) @(negedge clk);
        check_reset_values("in reset");
        check("hsize", {29'b0, hsize}, 32'h2);
        check("hburst", {29'b0, hburst}, 32'h0);
        check("hprot", {28'b0, hprot}, 32'h3);
        check("hmastlock", {31'b0, hmastlock}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        check_reset_values("after reset");

        // Directed table.
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                frame[i] = 16'(vecs[v].base);
                if (i == vecs[v].sc_cls) frame[i] = 16'(vecs[v].sc_val);
                if (i == vecs[v].pk_cls) frame[i] = 16'(vecs[v].pk_val);
            end
            aw[0] = vecs[v].aw0; dw[0] = vecs[v].dw0;
            aw[1] = vecs[v].aw1; dw[1] = vecs[v].dw1;
            drive_beats(0, vecs[v].n, 1'b0);
            expect_result(vecs[v].name, 5 + vecs[v].aw0 + vecs[v].dw0 + vecs[v].aw1 + vecs[v].dw1,
                          vecs[v].exp_code, vecs[v].exp_len, 1'b0, '0);
        end
        aw[0] = 0; dw[0] = 1; aw[1] = 0; dw[1] = 1;

        // Backpressure: the next frame's first beat waits on s_valid during
        // the writes and must become class 0 once the writer is idle again.
        for (int i = 0; i < 24; i++) frame[i] = (i == 7) ? 16'sd100 : -16'sd50;
        drive_beats(0, 24, 1'b0);
        expect_result("backpressure A", 7, 5'd7, 1'b0, 1'b1, 16'sd300);
        for (int i = 0; i < 24; i++) frame[i] = (i == 0) ? 16'sd300 : -16'sd5;
        drive_beats(1, 24, 1'b0);
        expect_result("backpressure B", 7, 5'd0, 1'b0, 1'b0, '0);

        // Reset during DATA0: bus idles at once and no done write follows.
        for (int i = 0; i < 24; i++) frame[i] = (i == 11) ? 16'sd77 : -16'sd1;
        drive_beats(0, 24, 1'b0);
        wr_log.delete();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check("mid-write in DATA0 htrans", {30'b0, htrans}, 32'd0);
        check("mid-write in DATA0 busy", {31'b0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check_reset_values("mid-write reset");
        @(negedge clk);
        resetn = 1'b1;
        dones  = 0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        foreach (wr_log[i]) if (wr_log[i].addr == DONE) dones++;
        check("mid-write no done write", dones, 0);
        check("mid-write no result pulse", pulses, 0);

        // Randomized frames against the reference model.
        for (int f = 0; f < 25; f++) begin
            int n = int'($urandom_range(1, 30));
            for (int i = 0; i < n; i++) begin
                tmp = int'($urandom_range(0, 60)) - 30;
                frame[i] = 16'(tmp);
            end
            aw[0] = int'($urandom_range(0, 2)); dw[0] = int'($urandom_range(0, 2));
            aw[1] = int'($urandom_range(0, 2)); dw[1] = int'($urandom_range(0, 2));
            model(n, mcode, mlen);
            drive_beats(0, n, 1'b1);
            expect_result($sformatf("random %0d", f), 5 + aw[0] + dw[0] + aw[1] + dw[1],
                          mcode, mlen, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/asl_result_writer.md
# asl_result_writer

Upstream neighbour of the seven-segment display slave. Consumes the classifier's per-class score stream (one signed score per ASL letter class) and computes the argmax with a confidence floor. Publishes the winning class index to the display slave as two AHB-Lite master writes: index to `SSD_BASE+0x0`, then done=1 to `SSD_BASE+0x4`.

## Interface
- `N_CLASSES`, 24: classes per frame; beats beyond this are ignored.
- `SCORE_W`, 16: signed score width.
- `CONF_THRESH`, 0: signed; a best score strictly below this reports code 24, which the display shows as 99.
- `SSD_BASE`, 32'hD000_0000: display slave base address.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `s_valid_i`  in  1  score beat valid.
- `s_ready_o`  out  1  score beat accepted when `s_valid_i` and `s_ready_o` are both 1.
- `s_data_i`  in  SCORE_W  signed score; beat k is class k.
- `s_last_i`  in  1  final beat of frame.
- `m_haddr_o`  out  32  AHB-L address.
- `m_htrans_o`  out  2  IDLE=2'b00, NONSEQ=2'b10.
- `m_hwrite_o`  out  1  write enable.
- `m_hsize_o`  out  3  constant 3'b010.
- `m_hburst_o`  out  3  constant 3'b000.
- `m_hprot_o`  out  4  constant 4'b0011.
- `m_hmastlock_o`  out  1  constant 0.
- `m_hwdata_o`  out  32  write data.
- `m_hready_i`  in  1  slave ready.
- `m_hresp_i`  in  1  ignored; the slave always returns OKAY.
- `result_o`  out  5  last published code (0-23, or 24 when below threshold).
- `result_valid_o`  out  1  one-cycle pulse when the done write completes.
- `busy_o`  out  1  high in any state other than ACCUM.
- `len_err_o`  out  1  the published frame had more than N_CLASSES beats.

## Operation
- **FSM states:** ACCUM, ADDR0, DATA0, ADDR1, DATA1.
- **ACCUM**
  - `s_ready_o`=1.
  - Beat counter `idx` (5b) increments per accepted beat and saturates at N_CLASSES.
  - On a beat with `idx` < N_CLASSES: if this is the first beat of the frame, or `s_data_i` > `best`, then `best`←`s_data_i` and `best_idx`←`idx`.
  - Ties keep the lower index.
  - On a beat with `idx` ≥ N_CLASSES: the beat is consumed, the argmax is unchanged, and the len_err latch sets.
  - An accepted beat with `s_last_i`=1 → ADDR0. Code latches as `best`<CONF_THRESH ? 24 : `best_idx`.
  - `idx`, `best` and the len_err latch reset for the next frame.
- **ADDR0:** `haddr`=SSD_BASE, `htrans`=NONSEQ, `hwrite`=1, `hwdata`={27'b0,code}. Held until `m_hready_i`=1, then → DATA0.
- **DATA0:** `htrans`=IDLE, `hwdata` held. Stays while `m_hready_i`=0; → ADDR1 on `m_hready_i`=1.
- **ADDR1 / DATA1:** same rules with `haddr`=SSD_BASE+4 and `hwdata`=32'h1.
  - DATA1 exit (`m_hready_i`=1) → ACCUM.
  - On that exit: `result_o`←code, `len_err_o`←latched len_err, `result_valid_o`=1 for one cycle.
- `hwdata` is driven during both address and data phase of each transfer, so slaves may sample it in either phase.
- Outside ADDR/DATA states: `htrans`=IDLE, `hwrite`=0, `haddr`=0, `hwdata`=0.

## Timing
- **Reset values:**
  - State ACCUM; `s_ready_o`=1.
  - `m_htrans_o`=IDLE, `m_hwrite_o`=0, `m_haddr_o`=0, `m_hwdata_o`=0.
  - `result_o`=0, `result_valid_o`=0, `busy_o`=0, `len_err_o`=0.
- All AHB outputs are registered.
- **Latency:**
  - `s_last` accepted at edge t → ADDR0 visible in cycle t+1.
  - With the display slave (one wait cycle per write), `result_valid_o` pulses in cycle t+7.
  - Each extra wait cycle on `m_hready_i` adds one cycle.
- `s_ready_o`=0 throughout ADDR0..DATA1; no beat is accepted or lost during this window.
- A frame of a single beat is valid: it yields that beat's index (or 24).
- A reset mid-transfer aborts immediately. `htrans` returns to IDLE and no done write is issued.
- `result_o` holds between frames.

## Structure
- Shared package `asl_pkg`:
  - HTRANS_IDLE, HTRANS_NSEQ.
  - The HSIZE_WORD constant.
  - Typedef `wr_state_t`.
  - Constant `NO_CONF_CODE`=5'd24.
- One natural sub-module, `score_argmax`: the ACCUM datapath (`idx`, `best`, `best_idx`, len_err). It exposes `code` and `frame_done`. The AHB master FSM stays in the top level.

## Test plan
- **Basic frame:** 24 beats, score 100 at class 7, all others -50 → write 0x7 to 0xD000_0000, write 0x1 to 0xD000_0004, `result_o`=7, one `result_valid_o` pulse.
- **Tie and negatives:** class 3 and class 12 both score 500 → `result_o`=3. All scores -10 with CONF_THRESH=0 → data 24 written, `result_o`=24.
- **Overlength frame:** 30 beats, maximum at beat 26 → max ignored, `result_o`=argmax of beats 0-23, `len_err_o`=1. The next good frame clears `len_err_o`.
- **Slave wait states:** `m_hready_i` held 0 for 3 cycles in ADDR0 and in DATA1 → addresses and data stable throughout, and `result_valid_o` is 6 cycles later than nominal.
- **Backpressure:** `s_valid_i` held 1 during the writes → `s_ready_o`=0, and the next frame starts with `idx`=0 after DATA1.
- **Reset mid-write:** assert `resetn`=0 in DATA0 → all outputs at reset values next cycle, and no write to 0xD000_0004 is observed.
